// File: rtl/gs_pkg.sv
// Shared encodings for the Gaussian-filter read-address sequencer.
package gs_pkg;

  localparam logic [1:0] BM_MIRROR = 2'd0;
  localparam logic [1:0] BM_REPL   = 2'd1;
  localparam logic [1:0] BM_ZERO   = 2'd2;

  localparam logic SEL_RAM0 = 1'b0;
  localparam logic SEL_RAM1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/gs_border_map.sv
// Maps a signed line index (-R..N-1+R) onto an in-range pixel index under the
// selected border policy; purely combinational.
module gs_border_map
  import gs_pkg::*;
#(
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned LEN_LOG2 = 8
) (
  input  logic signed [IDX_W-1:0]    idx_i,
  input  logic signed [IDX_W-1:0]    last_i,
  input  logic        [1:0]          mode_i,
  output logic        [LEN_LOG2-1:0] map_c,
  output logic                       pad_c
);

  logic signed [IDX_W-1:0] mapped;
  logic                    below;
  logic                    above;
  logic                    unused_hi;

  assign below = idx_i[IDX_W-1];
  assign above = idx_i > last_i;

  always_comb begin
    mapped = idx_i;
    pad_c  = 1'b0;
    if (below) begin
      unique case (mode_i)
        BM_MIRROR: mapped = -idx_i;
        BM_ZERO: begin
          mapped = '0;
          pad_c  = 1'b1;
        end
        BM_REPL:   mapped = '0;
        default:   mapped = '0;
      endcase
    end else if (above) begin
      unique case (mode_i)
        BM_MIRROR: mapped = (last_i <<< 1) - idx_i;
        BM_ZERO: begin
          mapped = '0;
          pad_c  = 1'b1;
        end
        BM_REPL:   mapped = last_i;
        default:   mapped = last_i;
      endcase
    end
  end

  assign map_c     = mapped[LEN_LOG2-1:0];
  assign unused_hi = ^mapped[IDX_W-1:LEN_LOG2];

endmodule

// File: rtl/gs_rd_addr_gen.sv
// Read-address sequencer: row-major pass over RAM0 then column-major pass over
// RAM1, each line extended by RADIUS taps per side, on a ready/valid stream.
module gs_rd_addr_gen
  import gs_pkg::*;
#(
  parameter int unsigned IMG_W_LOG2 = 8,
  parameter int unsigned IMG_H_LOG2 = 8,
  parameter int unsigned RADIUS     = 2,
  parameter int unsigned ADDR_W     = IMG_W_LOG2 + IMG_H_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pass_en,
  input  logic [1:0]        border_mode,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_pad,
  output logic              rd_sol,
  output logic              rd_eol,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OW = (IMG_W_LOG2 > IMG_H_LOG2) ? IMG_W_LOG2 : IMG_H_LOG2;
  localparam int unsigned IW = OW + 2;

  localparam logic signed [IW-1:0] I_FIRST = IW'(0) - IW'(RADIUS);
  localparam logic signed [IW-1:0] W_M1    = IW'((1 << IMG_W_LOG2) - 1);
  localparam logic signed [IW-1:0] H_M1    = IW'((1 << IMG_H_LOG2) - 1);
  localparam logic signed [IW-1:0] W_LAST  = W_M1 + IW'(RADIUS);
  localparam logic signed [IW-1:0] H_LAST  = H_M1 + IW'(RADIUS);
  localparam logic        [OW-1:0] O_W_M1  = OW'((1 << IMG_W_LOG2) - 1);
  localparam logic        [OW-1:0] O_H_M1  = OW'((1 << IMG_H_LOG2) - 1);

  state_e                  state_q, state_d;
  logic        [OW-1:0]    o_q, o_d;
  logic signed [IW-1:0]    i_q, i_d;
  logic        [1:0]       pe_q, pe_d;
  logic        [1:0]       bm_q, bm_d;
  logic                    valid_q, valid_d;
  logic                    sel_q, sel_d;
  logic        [ADDR_W-1:0] addr_q, addr_d;
  logic                    pad_q, pad_d;
  logic                    sol_q, sol_d;
  logic                    eol_q, eol_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    cur_p1, nxt_p1, line_end, outer_end;
  logic        [OW-1:0]    map_c;
  logic                    pad_c;

  // Next-state: counters move only on a handshake; abort overrides everything.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    pe_d    = pe_q;
    bm_d    = bm_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    cur_p1    = (state_q == ST_PASS1);
    line_end  = (i_q == (cur_p1 ? H_LAST : W_LAST));
    outer_end = (o_q == (cur_p1 ? O_W_M1 : O_H_M1));

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          pe_d = pass_en;
          bm_d = border_mode;
          o_d  = '0;
          i_d  = I_FIRST;
          if (pass_en == 2'b00) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = pass_en[0] ? ST_PASS0 : ST_PASS1;
            valid_d = 1'b1;
          end
        end
      end
      ST_PASS0, ST_PASS1: begin
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          o_d     = '0;
          i_d     = '0;
        end else if (!valid_q) begin
          // inter-pass bubble: counters already sit at the first pass-1 beat
          valid_d = 1'b1;
        end else if (rd_ready) begin
          if (!line_end) begin
            i_d = i_q + IW'(1);
          end else begin
            i_d = I_FIRST;
            if (!outer_end) begin
              o_d = o_q + OW'(1);
            end else begin
              o_d     = '0;
              valid_d = 1'b0;
              if (state_q == ST_PASS0 && pe_q[1]) begin
                state_d = ST_PASS1;
              end else begin
                state_d = ST_FIN;
                i_d     = '0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign nxt_p1 = (state_d == ST_PASS1);

  gs_border_map #(
    .IDX_W   (IW),
    .LEN_LOG2(OW)
  ) u_map (
    .idx_i (i_d),
    .last_i(nxt_p1 ? H_M1 : W_M1),
    .mode_i(bm_d),
    .map_c (map_c),
    .pad_c (pad_c)
  );

  // Output beat for the next cycle, built from the next counter values.
  always_comb begin
    sel_d  = nxt_p1 ? SEL_RAM1 : SEL_RAM0;
    busy_d = (state_d != ST_IDLE);
    addr_d = '0;
    pad_d  = 1'b0;
    sol_d  = 1'b0;
    eol_d  = 1'b0;
    if (valid_d) begin
      addr_d = nxt_p1 ? {map_c[IMG_H_LOG2-1:0], o_d[IMG_W_LOG2-1:0]}
                      : {o_d[IMG_H_LOG2-1:0], map_c[IMG_W_LOG2-1:0]};
      pad_d  = pad_c;
      sol_d  = (i_d == I_FIRST);
      eol_d  = (i_d == (nxt_p1 ? H_LAST : W_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      o_q     <= '0;
      i_q     <= '0;
      pe_q    <= '0;
      bm_q    <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      pad_q   <= 1'b0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      i_q     <= i_d;
      pe_q    <= pe_d;
      bm_q    <= bm_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      pad_q   <= pad_d;
      sol_q   <= sol_d;
      eol_q   <= eol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_sel   = sel_q;
  assign rd_addr  = addr_q;
  assign rd_pad   = pad_q;
  assign rd_sol   = sol_q;
  assign rd_eol   = eol_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
